// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_pkg;

   typedef enum logic [0:0] {
      STATE_IDLE  = 1'b0,
      STATE_GRANT = 1'b1
   } arb_state_e;

   // Burst counter must represent 0..MAX_BURST; unlimited bursts still need one bit.
   function automatic int burst_cnt_width(input int max_burst);
      int w;
      w = $clog2(max_burst + 1);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/rr_priority_select.sv
// Combinational round-robin pick: first requester at or after ptr_i, wrapping at NUM_PORTS.
module rr_priority_select #(
   parameter int NUM_PORTS = 4
) (
   input  logic [NUM_PORTS-1:0]         req_i,
   input  logic [$clog2(NUM_PORTS)-1:0] ptr_i,
   output logic [NUM_PORTS-1:0]         gnt_o,
   output logic                         any_req_o
);

   localparam int PW = $clog2(NUM_PORTS);

   logic [PW:0] idx_s;
   logic        found_s;

   // Scan from the pointer with modulo wrap so non-power-of-two port counts work.
   always_comb begin
      gnt_o   = '0;
      found_s = 1'b0;
      idx_s   = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         idx_s = {1'b0, ptr_i} + (PW+1)'(i);
         if (idx_s >= (PW+1)'(NUM_PORTS)) begin
            idx_s = idx_s - (PW+1)'(NUM_PORTS);
         end else begin
            idx_s = idx_s;
         end
         if (!found_s && req_i[idx_s[PW-1:0]]) begin
            gnt_o[idx_s[PW-1:0]] = 1'b1;
            found_s              = 1'b1;
         end else begin
            found_s = found_s;
         end
      end
   end

   assign any_req_o = |req_i;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NUM_PORTS AXI-Stream sources,
// with zero-latency pass-through of the granted stream.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NUM_PORTS  = 4,
   parameter int WORD_WIDTH = 8,
   parameter int MAX_BURST  = 16
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_PORTS*WORD_WIDTH-1:0] din_axis_tdata,
   input  logic [NUM_PORTS-1:0]            din_axis_tvalid,
   input  logic [NUM_PORTS-1:0]            din_axis_tlast,
   output logic [NUM_PORTS-1:0]            din_axis_tready,
   output logic [WORD_WIDTH-1:0]           dout_axis_tdata,
   output logic                            dout_axis_tvalid,
   input  logic                            dout_axis_tready,
   output logic [NUM_PORTS-1:0]            grant,
   output logic                            busy
);

   localparam int PW = $clog2(NUM_PORTS);
   localparam int CW = burst_cnt_width(MAX_BURST);

   arb_state_e           state_q, state_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [PW-1:0]        owner_q, owner_d;
   logic [PW-1:0]        last_owner_q, last_owner_d;
   logic [CW-1:0]        cnt_q, cnt_d;

   logic [PW-1:0]         ptr_s, sel_idx_s;
   logic [NUM_PORTS-1:0]  sel_gnt_s;
   logic                  any_req_s;
   logic [WORD_WIDTH-1:0] own_data_s;
   logic                  own_valid_s, own_last_s;
   logic                  xfer_s, burst_hit_s, release_s;

   assign ptr_s = (last_owner_q == PW'(NUM_PORTS-1)) ? '0 : last_owner_q + PW'(1);

   rr_priority_select #(.NUM_PORTS(NUM_PORTS)) u_rr_sel (
      .req_i    (din_axis_tvalid),
      .ptr_i    (ptr_s),
      .gnt_o    (sel_gnt_s),
      .any_req_o(any_req_s)
   );

   // One-hot to index; the select output has at most one bit set.
   always_comb begin
      sel_idx_s = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         sel_idx_s = sel_idx_s | (sel_gnt_s[i] ? PW'(i) : '0);
      end
   end

   assign own_data_s  = din_axis_tdata[owner_q*WORD_WIDTH +: WORD_WIDTH];
   assign own_valid_s = din_axis_tvalid[owner_q];
   assign own_last_s  = din_axis_tlast[owner_q];
   assign xfer_s      = (state_q == STATE_GRANT) && own_valid_s && dout_axis_tready;
   assign burst_hit_s = (MAX_BURST != 0) &&
                        (({1'b0, cnt_q} + (CW+1)'(1)) == (CW+1)'(MAX_BURST));
   assign release_s   = xfer_s && (own_last_s || burst_hit_s);

   // State register; reset leaves the pointer so port 0 is searched first.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q      <= STATE_IDLE;
         grant_q      <= '0;
         owner_q      <= '0;
         last_owner_q <= PW'(NUM_PORTS-1);
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         cnt_q        <= cnt_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      cnt_d        = cnt_q;
      case (state_q)
         STATE_IDLE: begin
            if (any_req_s) begin
               state_d = STATE_GRANT;
               grant_d = sel_gnt_s;
               owner_d = sel_idx_s;
               cnt_d   = '0;
            end else begin
               state_d = STATE_IDLE;
            end
         end
         STATE_GRANT: begin
            if (release_s) begin
               state_d      = STATE_IDLE;
               grant_d      = '0;
               last_owner_d = owner_q;
               cnt_d        = '0;
            end else if (xfer_s) begin
               cnt_d = cnt_q + CW'(1);
            end else begin
               cnt_d = cnt_q;
            end
         end
         default: begin
            state_d = STATE_IDLE;
            grant_d = '0;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs come straight from state so reset silences the bus without a clock edge.
   always_comb begin
      dout_axis_tdata  = '0;
      dout_axis_tvalid = 1'b0;
      din_axis_tready  = '0;
      if (state_q == STATE_GRANT) begin
         dout_axis_tdata  = own_data_s;
         dout_axis_tvalid = own_valid_s;
         din_axis_tready  = grant_q & {NUM_PORTS{dout_axis_tready}};
      end else begin
         dout_axis_tdata  = '0;
         dout_axis_tvalid = 1'b0;
         din_axis_tready  = '0;
      end
   end

   assign grant = grant_q;
   assign busy  = (state_q == STATE_GRANT);

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares one UART transmitter between NUM_PORTS AXI-Stream sources, for example a command responder, a status reporter and a debug tap.
- Each upstream port presents words with tlast marking the end of a packet.
- The arbiter grants one port at a time and passes its stream through to the transmitter's AXI-Stream input.
- A grant ends on tlast or after MAX_BURST words, so no source can starve the others.

Parameters:
- NUM_PORTS, 4, number of requesting AXI-Stream sources (2..16).
- WORD_WIDTH, 8, data width per word; matches the transmitter word width.
- MAX_BURST, 16, maximum words per grant before forced rotation; 0 = unlimited (release only on tlast).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-low reset (0 = reset).
- din_axis_tdata  input  NUM_PORTS*WORD_WIDTH  packed source data; port i occupies bits [i*WORD_WIDTH +: WORD_WIDTH].
- din_axis_tvalid  input  NUM_PORTS  per-port valid.
- din_axis_tlast  input  NUM_PORTS  per-port end of packet.
- din_axis_tready  output  NUM_PORTS  per-port ready.
- dout_axis_tdata  output  WORD_WIDTH  data to transmitter.
- dout_axis_tvalid  output  1  valid to transmitter.
- dout_axis_tready  input  1  transmitter ready.
- grant  output  NUM_PORTS  one-hot current owner; all zero when idle.
- busy  output  1  high while a grant is held.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=STATE_IDLE, grant=0, busy=0, burst counter=0.
  - Priority pointer is set so port 0 has highest priority.
  - dout_axis_tvalid=0 and din_axis_tready=0 take effect immediately, without waiting for a clock edge.
- FSM states: STATE_IDLE, STATE_GRANT.
- STATE_IDLE:
  - Combinational round-robin search over din_axis_tvalid, starting at index (last_owner+1) mod NUM_PORTS.
  - If any valid: register grant one-hot, clear counter, next state STATE_GRANT.
  - If no valid: remain in STATE_IDLE.
  - Outputs in this state: dout_axis_tvalid=0, all din_axis_tready=0.
- STATE_GRANT, pass-through with zero latency:
  - dout_axis_tdata = granted port's data.
  - dout_axis_tvalid = granted port's tvalid.
  - din_axis_tready[owner] = dout_axis_tready; all other readies 0.
  - No registered stage in the data path.
- Transfer (grant valid & ready): counter increments. Release when:
  - the transfer carries tlast=1, or
  - MAX_BURST != 0 and counter+1 == MAX_BURST.
- On release:
  - next state STATE_IDLE, grant=0, last_owner = current owner.
  - There is exactly one bubble cycle between consecutive grants.
- Arbitration latency: tvalid rising at cycle N while idle gives grant and dout_axis_tvalid high in cycle N+1.
- Backpressure (dout_axis_tready=0): no counter change, no release. The source's AXI-Stream rules keep tdata stable.
- Owner drops tvalid mid-packet: the grant is held; the arbiter waits for tlast or the burst limit. There is no timeout.
- Simultaneous requests: the round-robin pointer decides. After reset, the lowest index wins.
- tlast and burst limit on the same transfer: a single release.
- Counter width: $clog2(MAX_BURST+1), minimum 1 bit.
- Reset mid-burst: immediate abort. The partially sent packet is not resumed; the upstream source is responsible for recovery.
- busy = (state == STATE_GRANT).

Decomposition:
- uart_pkg holds:
  - typedef enum for arbiter state (STATE_IDLE, STATE_GRANT);
  - a function returning burst counter width.
- One sub-module, rr_priority_select: purely combinational.
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and any_request.
  - Parameterised by NUM_PORTS.

Test Plan:
1. Single packet: port 0 sends A5, 5A, FF (tlast on FF), dout_axis_tready=1.
   - grant=0001 one cycle after tvalid.
   - dout_axis_tdata sequence A5, 5A, FF on consecutive cycles.
   - grant=0000 and busy=0 the cycle after FF.
2. Contention from reset: ports 0 and 2 each assert one-word packets (11, 22) in the same cycle.
   - 11 is sent first with grant=0001.
   - One idle cycle follows.
   - 22 is sent with grant=0100.
3. Fairness: all four ports continuously offer one-word packets.
   - Grant order is 0001, 0010, 0100, 1000, 0001.
   - Every port gets exactly 2 words in 8 grants.
4. Burst limit (MAX_BURST=4): port 1 streams 10 words with no tlast while port 3 has a one-word packet pending.
   - Port 1 sends 4 words, then port 3 sends its word, then port 1 resumes with word 5.
5. Backpressure: dout_axis_tready=0 for 5 cycles in the middle of a 3-word packet.
   - dout_axis_tdata holds its value.
   - din_axis_tready[owner]=0.
   - Counter is unchanged; the packet completes intact once ready returns.
6. Reset mid-burst: rst=0 during word 2 of port 1.
   - grant=0, dout_axis_tvalid=0 before the next clock edge.
   - After rst=1, port 0 has highest priority again.
